dtack_berr_gen: RTL and testbench

DTACK_BERR_GEN -- requirements
Module: dtack_berr_gen

---
 rtl/dtack_berr_gen.sv | 128 ++++++++++++
 tb/tb_dtack_berr_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dtack_berr_gen.sv
// 68000-style bus cycle terminator: generates DTACK after per-device wait states,
// or BERR on decode conflict / watchdog timeout, with sticky error flag and count.
module dtack_berr_gen #(
    parameter int unsigned ROM_WAIT     = 2,
    parameter int unsigned RAM_WAIT     = 0,
    parameter int unsigned DUA_WAIT     = 3,
    parameter int unsigned BERR_TIMEOUT = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AS_n,
    input  logic       DS_n,
    input  logic       ROMSEL_n,
    input  logic       RAMSEL1_n,
    input  logic       DUASEL_n,
    input  logic       EXPSEL_n,
    input  logic       EXPDTACK_n,
    input  logic       VPA_n,
    output logic       DTACK_n,
    output logic       BERR_n,
    output logic       TIMEOUT_FLAG,
    output logic [7:0] BERR_COUNT
);

    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EXPWAIT,
        ST_ACK,
        ST_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic [CW-1:0]   wd_q, wd_d;
    logic [2:0]      sel_cnt_c;
    logic [CW-1:0]   load_c;
    logic            active_c;

    // Number of asserted chip selects; more than one is a decode conflict.
    assign sel_cnt_c = {2'b00, ~ROMSEL_n} + {2'b00, ~RAMSEL1_n}
                     + {2'b00, ~DUASEL_n} + {2'b00, ~EXPSEL_n};

    assign load_c = !ROMSEL_n  ? CW'(ROM_WAIT) :
                    !RAMSEL1_n ? CW'(RAM_WAIT) : CW'(DUA_WAIT);

    assign active_c = (state_q == ST_IDLE) || (state_q == ST_WAIT) ||
                      (state_q == ST_EXPWAIT);

    // Next-state, wait countdown and watchdog.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        wd_d    = wd_q;

        if (AS_n) begin
            wd_d = '0;
        end else if (active_c && VPA_n && (wd_q != '1)) begin
            wd_d = wd_q + CW'(1);
        end

        if (active_c) begin
            if (AS_n || !VPA_n) begin
                state_d = ST_IDLE;
            end else if (wd_q == CW'(BERR_TIMEOUT)) begin
                state_d = ST_ERR;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!DS_n) begin
                            if (sel_cnt_c > 3'd1) begin
                                state_d = ST_ERR;
                            end else if (sel_cnt_c == 3'd1 && !EXPSEL_n) begin
                                state_d = ST_EXPWAIT;
                            end else if (sel_cnt_c == 3'd1) begin
                                wait_d  = load_c;
                                state_d = (load_c == '0) ? ST_ACK : ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (wait_q == CW'(1)) begin
                            state_d = ST_ACK;
                        end else begin
                            wait_d = wait_q - CW'(1);
                        end
                    end
                    ST_EXPWAIT: begin
                        if (!EXPDTACK_n) state_d = ST_ACK;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (state_q == ST_ACK) begin
            // VPA overrides a pending acknowledge so DTACK never overlaps an autovector cycle.
            if (AS_n || !VPA_n) state_d = ST_IDLE;
        end else if (state_q == ST_ERR) begin
            if (AS_n) state_d = ST_IDLE;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            wd_q         <= '0;
            DTACK_n      <= 1'b1;
            BERR_n       <= 1'b1;
            TIMEOUT_FLAG <= 1'b0;
            BERR_COUNT   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            wd_q    <= wd_d;
            DTACK_n <= (state_d != ST_ACK);
            BERR_n  <= (state_d != ST_ERR);
            if (state_d == ST_ERR && state_q != ST_ERR) begin
                TIMEOUT_FLAG <= 1'b1;
                if (BERR_COUNT != '1) BERR_COUNT <= BERR_COUNT + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dtack_berr_gen.sv
// Bench for dtack_berr_gen: directed vector table, multi-cycle corner sequences,
// and random bus cycles checked against a deadline-based reference model.
module tb_dtack_berr_gen;

    localparam int T_ROM = 2;
    localparam int T_RAM = 0;
    localparam int T_DUA = 3;
    localparam int T_TO  = 64;

    logic       clk;
    logic       rst, as_n, ds_n, romsel_n, ramsel1_n, duasel_n, expsel_n, expdtack_n, vpa_n;
    logic       dtack_n, berr_n, timeout_flag;
    logic [7:0] berr_count;

    int checks = 0;
    int errors = 0;

    dtack_berr_gen #(
        .ROM_WAIT(T_ROM), .RAM_WAIT(T_RAM), .DUA_WAIT(T_DUA), .BERR_TIMEOUT(T_TO)
    ) dut (
        .CLK(clk), .RST(rst), .AS_n(as_n), .DS_n(ds_n),
        .ROMSEL_n(romsel_n), .RAMSEL1_n(ramsel1_n), .DUASEL_n(duasel_n), .EXPSEL_n(expsel_n),
        .EXPDTACK_n(expdtack_n), .VPA_n(vpa_n),
        .DTACK_n(dtack_n), .BERR_n(berr_n), .TIMEOUT_FLAG(timeout_flag), .BERR_COUNT(berr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a cycle is either acknowledged, errored, or pending until an absolute edge.
    bit m_ack = 0, m_err = 0, m_pend = 0, m_exp = 0, m_flag = 0;
    int m_ack_at = 0, m_wd = 0, m_n = 0, m_cnt = 0;

    task automatic model_edge();
        bit new_err;
        int nsel, w;
        new_err = 0;
        m_n++;
        if (rst) begin
            m_ack = 0; m_err = 0; m_pend = 0; m_exp = 0; m_flag = 0;
            m_wd = 0; m_cnt = 0;
        end else if (m_ack || m_err) begin
            if (as_n || (m_ack && !vpa_n)) begin
                m_ack = 0; m_err = 0;
            end
            if (as_n) m_wd = 0;
        end else if (as_n) begin
            m_pend = 0; m_wd = 0;
        end else if (!vpa_n) begin
            m_pend = 0;
        end else begin
            nsel = int'(!romsel_n) + int'(!ramsel1_n) + int'(!duasel_n) + int'(!expsel_n);
            if (m_wd == T_TO) begin
                m_err = 1; m_pend = 0; new_err = 1;
            end else if (!m_pend) begin
                if (!ds_n && nsel > 1) begin
                    m_err = 1; new_err = 1;
                end else if (!ds_n && nsel == 1) begin
                    if (!expsel_n) begin
                        m_exp = 1; m_pend = 1;
                    end else begin
                        w = !romsel_n ? T_ROM : (!ramsel1_n ? T_RAM : T_DUA);
                        m_exp = 0;
                        if (w == 0) m_ack = 1;
                        else begin m_pend = 1; m_ack_at = m_n + w; end
                    end
                end
            end else if (m_exp ? !expdtack_n : (m_n == m_ack_at)) begin
                m_ack = 1; m_pend = 0;
            end
            if (m_wd < 255) m_wd++;
        end
        if (new_err) begin
            m_flag = 1;
            if (m_cnt < 255) m_cnt++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: actual=%0d expected=%0d", name, m_n, act, exp);
        end
    endtask

    // One clock edge; outputs sampled 1 time unit after it and compared to the model.
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check("model_dtack", 32'(dtack_n), m_ack ? 32'd0 : 32'd1);
        check("model_berr", 32'(berr_n), m_err ? 32'd0 : 32'd1);
        check("model_flag", 32'(timeout_flag), 32'(m_flag));
        check("model_count", 32'(berr_count), 32'(m_cnt));
        check("dtack_berr_exclusive", 32'(!dtack_n && !berr_n), 32'd0);
    endtask

    // Stimulus order: rst as ds rom ram dua exp expdtack vpa
    task automatic drive(input logic [8:0] v);
        {rst, as_n, ds_n, romsel_n, ramsel1_n, duasel_n, expsel_n, expdtack_n, vpa_n} = v;
    endtask

    typedef struct packed {
        logic [8:0] stim;
        logic       dtack;
        logic       berr;
        logic       flag;
        logic [7:0] cnt;
    } vec_t;

    localparam logic [8:0] IDLE_V = 9'b0_11_1111_1_1;
    localparam logic [8:0] RST_V  = 9'b1_11_1111_1_1;

    vec_t tbl[21];

    initial begin
        bit   saw_low;
        logic [3:0] s;
        int   len, r;
        logic vpa_t;

        tbl[0]  = {RST_V,            1'b1, 1'b1, 1'b0, 8'd0};
        tbl[1]  = {9'b0_00_1011_1_1, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[2]  = {9'b0_00_1011_1_1, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[3]  = {IDLE_V,           1'b1, 1'b1, 1'b0, 8'd0};
        tbl[4]  = {9'b0_00_0111_1_1, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[5]  = {9'b0_00_0111_1_1, 1'b1, 1'b1, 1'b0, 8'd0};
        tbl[6]  = {9'b0_00_0111_1_1, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[7]  = {9'b0_00_0111_1_1, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[8]  = {IDLE_V,           1'b1, 1'b1, 1'b0, 8'd0};
        tbl[9]  = {9'b0_00_0101_1_1, 1'b1, 1'b0, 1'b1, 8'd1};
        tbl[10] = {9'b0_00_0101_1_1, 1'b1, 1'b0, 1'b1, 8'd1};
        tbl[11] = {IDLE_V,           1'b1, 1'b1, 1'b1, 8'd1};
        tbl[12] = {9'b0_00_1101_1_1, 1'b1, 1'b1, 1'b1, 8'd1};
        tbl[13] = {IDLE_V,           1'b1, 1'b1, 1'b1, 8'd1};
        tbl[14] = {IDLE_V,           1'b1, 1'b1, 1'b1, 8'd1};
        tbl[15] = {9'b0_00_1110_1_1, 1'b1, 1'b1, 1'b1, 8'd1};
        tbl[16] = {9'b0_00_1110_0_1, 1'b0, 1'b1, 1'b1, 8'd1};
        tbl[17] = {IDLE_V,           1'b1, 1'b1, 1'b1, 8'd1};
        tbl[18] = {9'b0_00_0111_1_0, 1'b1, 1'b1, 1'b1, 8'd1};
        tbl[19] = {9'b0_00_0111_1_0, 1'b1, 1'b1, 1'b1, 8'd1};
        tbl[20] = {IDLE_V,           1'b1, 1'b1, 1'b1, 8'd1};

        drive(RST_V);
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].stim);
            step();
            check($sformatf("tbl%0d_dtack", i), 32'(dtack_n), 32'(tbl[i].dtack));
            check($sformatf("tbl%0d_berr", i), 32'(berr_n), 32'(tbl[i].berr));
            check($sformatf("tbl%0d_flag", i), 32'(timeout_flag), 32'(tbl[i].flag));
            check($sformatf("tbl%0d_count", i), 32'(berr_count), 32'(tbl[i].cnt));
        end

        // Expansion card never acknowledges: watchdog bus error after edge 64.
        drive(RST_V); step();
        drive(9'b0_00_1110_1_1);
        for (int e = 0; e <= 64; e++) begin
            step();
            if (e == 63) check("exp_to_berr_e63", 32'(berr_n), 32'd1);
            if (e == 64) begin
                check("exp_to_berr_e64", 32'(berr_n), 32'd0);
                check("exp_to_flag", 32'(timeout_flag), 32'd1);
                check("exp_to_count", 32'(berr_count), 32'd1);
            end
        end
        drive(IDLE_V); step();

        // Expansion acknowledge sampled at edge 10.
        drive(9'b0_00_1110_1_1);
        for (int e = 0; e <= 10; e++) begin
            if (e == 10) expdtack_n = 1'b0;
            step();
            if (e == 9)  check("exp_ack_e9", 32'(dtack_n), 32'd1);
            if (e == 10) check("exp_ack_e10", 32'(dtack_n), 32'd0);
        end
        drive(IDLE_V); step();

        // Reset asserted while acknowledging a ROM cycle.
        drive(9'b0_00_0111_1_1);
        for (int e = 0; e < 3; e++) step();
        check("rst_pre_ack", 32'(dtack_n), 32'd0);
        drive(9'b1_00_0111_1_1); step();
        check("rst_ack_dtack", 32'(dtack_n), 32'd1);
        check("rst_ack_berr", 32'(berr_n), 32'd1);
        check("rst_ack_flag", 32'(timeout_flag), 32'd0);
        check("rst_ack_count", 32'(berr_count), 32'd0);
        drive(IDLE_V); step();

        // Interrupt acknowledge held 100 edges with VPA asserted.
        drive(9'b0_00_1111_1_0);
        saw_low = 0;
        for (int e = 0; e < 100; e++) begin
            step();
            if (!dtack_n || !berr_n) saw_low = 1;
        end
        check("iack_no_term", 32'(saw_low), 32'd0);
        drive(IDLE_V); step();

        // 256 unmapped accesses saturate the error count.
        drive(RST_V); step();
        for (int k = 0; k < 256; k++) begin
            drive(9'b0_00_1111_1_1);
            for (int e = 0; e <= 64; e++) step();
            if (k == 0) check("unmapped_berr_e64", 32'(berr_n), 32'd0);
            drive(IDLE_V); step();
        end
        check("sat_count", 32'(berr_count), 32'd255);
        check("sat_flag", 32'(timeout_flag), 32'd1);

        // Random bus cycles against the reference model.
        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 9);
            s = 4'b1111;
            if (r < 6) s[$urandom_range(0, 3)] = 1'b0;
            else if (r < 8) begin
                s[$urandom_range(0, 3)] = 1'b0;
                s[$urandom_range(0, 3)] = 1'b0;
            end
            vpa_t = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 80)) : int'($urandom_range(1, 12));
            for (int e = 0; e < len; e++) begin
                rst        = ($urandom_range(0, 199) == 0);
                as_n       = 1'b0;
                ds_n       = (e == 0 && $urandom_range(0, 3) == 0);
                {romsel_n, ramsel1_n, duasel_n, expsel_n} = s;
                expdtack_n = ($urandom_range(0, 5) != 0);
                vpa_n      = vpa_t;
                step();
            end
            drive(IDLE_V);
            len = int'($urandom_range(1, 2));
            for (int e = 0; e < len; e++) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
